// File: rtl/mm_seq_pkg.sv
// Shared opcodes, instruction codes, FSM states and timing constants for the
// multi-MAC command sequencer.
package mm_seq_pkg;

  localparam logic [1:0] OP_CONFIG = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_CRST   = 2'b11;

  localparam logic [1:0] INSN_MIN  = 2'b00;
  localparam logic [1:0] INSN_MAX  = 2'b01;
  localparam logic [1:0] INSN_MADD = 2'b10;

  localparam logic [6:0] RUN_ZERO_LEN = 7'd64;
  localparam logic [6:0] CRST_LEN     = 7'd2;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    LD_WAIT,
    LD_PULSE,
    RUN,
    CRST,
    GAP
  } seq_state_e;

  // A zero run length encodes the longest run the 6-bit field cannot express.
  function automatic logic [6:0] run_len(input logic [5:0] n);
    return (n == 6'd0) ? RUN_ZERO_LEN : {1'b0, n};
  endfunction

endpackage

// File: rtl/mm_cmd_fifo.sv
// Circular command-byte buffer with a registered ready flag derived from the
// next-cycle occupancy, so a pop on a full buffer cannot admit a same-cycle write.
module mm_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ready,
  output logic             o_nonempty_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             r_ready;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_ready   = r_ready;
  assign o_nonempty_next = (w_count_next != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mm_cmd_sequencer.sv
// Byte-stream command sequencer driving the multi-MAC core pins.
// MM_SEQ_BUFFER_EN selects a CMD_DEPTH-entry buffer; otherwise a one-byte holding register.
module mm_cmd_sequencer
  import mm_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  output logic       o_core_rst_n,
  output logic [1:0] o_core_insn,
  output logic [3:0] o_core_index,
  output logic [3:0] o_core_data,
  output logic       o_core_load,
  output logic       o_core_run,
  output logic       o_busy
);

  logic [7:0] w_head;
  logic       w_empty;
  logic       w_ready;
  logic       w_nonempty_next;
  logic       w_push;
  logic       w_pop;

  assign w_push      = i_cmd_valid && w_ready;
  assign o_cmd_ready = w_ready;

`ifdef MM_SEQ_BUFFER_EN
  mm_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_push          (w_push),
    .i_data          (i_cmd_data),
    .i_pop           (w_pop),
    .o_data          (w_head),
    .o_empty         (w_empty),
    .o_ready         (w_ready),
    .o_nonempty_next (w_nonempty_next)
  );
`else
  logic       r_hold_full;
  logic [7:0] r_hold_data;
  logic       r_hold_ready;
  logic       w_hold_full_next;

  // CMD_DEPTH has no meaning for the holding register.
  if (CMD_DEPTH < 2) begin : g_depth_unused
  end

  assign w_hold_full_next = w_push ? 1'b1 : (w_pop ? 1'b0 : r_hold_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full  <= 1'b0;
      r_hold_data  <= '0;
      r_hold_ready <= 1'b0;
    end else begin
      if (w_push) r_hold_data <= i_cmd_data;
      r_hold_full  <= w_hold_full_next;
      r_hold_ready <= !w_hold_full_next;
    end
  end

  assign w_head          = r_hold_data;
  assign w_empty         = !r_hold_full;
  assign w_ready         = r_hold_ready;
  assign w_nonempty_next = w_hold_full_next;
`endif

  seq_state_e r_state;
  seq_state_e w_state_next;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_next;
  logic [1:0] r_insn;
  logic [1:0] w_insn_next;
  logic [3:0] r_index;
  logic [3:0] w_index_next;
  logic [3:0] r_data;
  logic [3:0] w_data_next;
  logic       r_load;
  logic       r_run;
  logic       r_core_rst_n;
  logic       r_busy;
  logic       w_busy_next;
  logic [1:0] w_opcode;
  logic       w_cfg_legal;

  assign w_opcode    = w_head[7:6];
  assign w_cfg_legal = (w_head[1:0] == INSN_MIN) || (w_head[1:0] == INSN_MAX) ||
                       (w_head[1:0] == INSN_MADD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_insn       <= INSN_MIN;
      r_index      <= '0;
      r_data       <= '0;
      r_load       <= 1'b0;
      r_run        <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_insn       <= w_insn_next;
      r_index      <= w_index_next;
      r_data       <= w_data_next;
      r_load       <= (w_state_next == LD_PULSE);
      r_run        <= (w_state_next == RUN);
      r_core_rst_n <= (w_state_next != CRST);
      r_busy       <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (!w_empty) w_state_next = DECODE;
      DECODE: begin
        case (w_opcode)
          OP_CONFIG: w_state_next = GAP;
          OP_LOAD:   w_state_next = LD_WAIT;
          OP_RUN:    w_state_next = RUN;
          default:   w_state_next = CRST;
        endcase
      end
      LD_WAIT:  if (!w_empty) w_state_next = LD_PULSE;
      LD_PULSE: w_state_next = GAP;
      // Exit on 1 so the strobe stays high for exactly the loaded count.
      RUN, CRST: if (r_cnt == 7'd1) w_state_next = GAP;
      GAP:      w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop        = 1'b0;
    w_cnt_next   = r_cnt;
    w_insn_next  = r_insn;
    w_index_next = r_index;
    w_data_next  = r_data;
    case (r_state)
      DECODE: begin
        w_pop = 1'b1;
        case (w_opcode)
          OP_CONFIG: if (w_cfg_legal) w_insn_next = w_head[1:0];
          OP_LOAD:   w_index_next = w_head[3:0];
          OP_RUN:    w_cnt_next = run_len(w_head[5:0]);
          default:   w_cnt_next = CRST_LEN;
        endcase
      end
      LD_WAIT: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_data_next = w_head[3:0];
        end
      end
      RUN, CRST: w_cnt_next = r_cnt - 7'd1;
      default: ;
    endcase
  end

  assign w_busy_next = w_nonempty_next || (w_state_next != IDLE);

  assign o_core_rst_n = r_core_rst_n;
  assign o_core_insn  = r_insn;
  assign o_core_index = r_index;
  assign o_core_data  = r_data;
  assign o_core_load  = r_load;
  assign o_core_run   = r_run;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_mm_cmd_sequencer.sv
// Self-checking bench for mm_cmd_sequencer: directed protocol checks plus random
// command streams compared, event by event, against a command-level model.
module tb_mm_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready;
  logic       core_rst_n;
  logic [1:0] core_insn;
  logic [3:0] core_index;
  logic [3:0] core_data;
  logic       core_load;
  logic       core_run;
  logic       busy;

  mm_cmd_sequencer #(.CMD_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .i_cmd_data   (cmd_data),
    .o_cmd_ready  (cmd_ready),
    .o_core_rst_n (core_rst_n),
    .o_core_insn  (core_insn),
    .o_core_index (core_index),
    .o_core_data  (core_data),
    .o_core_load  (core_load),
    .o_core_run   (core_run),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  localparam int EV_INSN = 0;
  localparam int EV_LOAD = 1;
  localparam int EV_RUN  = 2;
  localparam int EV_CRST = 3;

  typedef struct {
    int kind;
    int a;
    int b;
    int len;
    int t;
  } ev_t;

  function automatic ev_t mk_ev(input int kind, input int a, input int b, input int len, input int t);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.len = len; e.t = t;
    return e;
  endfunction

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        last_obs[$];
  logic [7:0] sent_q[$];
  int         model_insn = 0;
  int         last_acc = 0;
  int         busy_fall_t = 0;
  logic       mon_en = 1'b0;

  // Monitor: turns pin activity into command-level events and checks pin invariants.
  initial begin
    int   run_len = 0, rst_len = 0, load_len = 0;
    int   run_t = 0, rst_t = 0, ld_t = 0, ld_idx = 0, ld_dat = 0;
    int   gap = -1;
    logic prev_strobe = 1'b0, prev_busy = 1'b0, strobe;
    logic [1:0] prev_insn = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        run_len = 0; rst_len = 0; load_len = 0; gap = -1;
        prev_strobe = 1'b0; prev_busy = busy; prev_insn = core_insn;
      end else begin
        if (core_load) begin
          if (load_len == 0) begin ld_idx = core_index; ld_dat = core_data; ld_t = cyc; end
          load_len++;
        end else if (load_len != 0) begin
          obs_q.push_back(mk_ev(EV_LOAD, ld_idx, ld_dat, load_len, ld_t));
          load_len = 0;
        end
        if (core_run) begin
          if (run_len == 0) run_t = cyc;
          run_len++;
        end else if (run_len != 0) begin
          obs_q.push_back(mk_ev(EV_RUN, 0, 0, run_len, run_t));
          run_len = 0;
        end
        if (!core_rst_n) begin
          if (rst_len == 0) rst_t = cyc;
          rst_len++;
        end else if (rst_len != 0) begin
          obs_q.push_back(mk_ev(EV_CRST, 0, 0, rst_len, rst_t));
          rst_len = 0;
        end
        if (core_insn != prev_insn) obs_q.push_back(mk_ev(EV_INSN, int'(core_insn), 0, 0, cyc));
        prev_insn = core_insn;
        if (prev_busy && !busy) busy_fall_t = cyc;
        prev_busy = busy;
        check("load_run_overlap", int'(core_load && core_run), 0);
        check("rst_with_strobe", int'(!core_rst_n && (core_load || core_run)), 0);
        strobe = core_load || core_run || !core_rst_n;
        if (strobe && !prev_strobe && gap >= 0) check("strobe_gap_ge2", int'(gap >= 2), 1);
        if (strobe) gap = 0;
        else if (gap >= 0) gap++;
        prev_strobe = strobe;
      end
    end
  end

  // Caller must be at a negedge; returns at the negedge after acceptance.
  task automatic push_byte(input logic [7:0] b);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      last_acc = cyc + 1;
      sent_q.push_back(b);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_run(input string tag);
    int g = 0;
    while (!core_run && g < 300) begin
      @(negedge clk);
      g++;
    end
    check(tag, int'(core_run), 1);
  endtask

  // Model: each command byte maps to one observable effect on the core pins.
  task automatic build_expected();
    int i = 0;
    logic [7:0] cb, db;
    exp_q.delete();
    while (i < sent_q.size()) begin
      cb = sent_q[i];
      i++;
      case (cb[7:6])
        2'b00: begin
          if (cb[1:0] != 2'b11 && int'(cb[1:0]) != model_insn) begin
            model_insn = int'(cb[1:0]);
            exp_q.push_back(mk_ev(EV_INSN, model_insn, 0, 0, 0));
          end
        end
        2'b01: begin
          db = (i < sent_q.size()) ? sent_q[i] : 8'h00;
          i++;
          exp_q.push_back(mk_ev(EV_LOAD, int'(cb[3:0]), int'(db[3:0]), 1, 0));
        end
        2'b10: exp_q.push_back(mk_ev(EV_RUN, 0, 0, (cb[5:0] == 6'd0) ? 64 : int'(cb[5:0]), 0));
        default: exp_q.push_back(mk_ev(EV_CRST, 0, 0, 2, 0));
      endcase
    end
  endtask

  task automatic compare_events(input string tag);
    int idle = 0, guard = 0, n;
    while (idle < 3 && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (!busy && !cmd_valid) idle++;
      else idle = 0;
    end
    check({tag, "_drain"}, int'(idle >= 3), 1);
    build_expected();
    check({tag, "_nevents"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check({tag, "_a"},    obs_q[i].a,    exp_q[i].a);
      check({tag, "_b"},    obs_q[i].b,    exp_q[i].b);
      check({tag, "_len"},  obs_q[i].len,  exp_q[i].len);
    end
    last_obs = obs_q;
    obs_q.delete();
    sent_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n_before, stall_seen;
    logic [7:0] bp_bytes [8];
    bp_bytes = '{8'h01, 8'h4A, 8'h37, 8'h03, 8'h82, 8'h43, 8'hFC, 8'h02};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_core_rst_n", int'(core_rst_n), 0);
    check("rst_insn", int'(core_insn), 0);
    check("rst_index", int'(core_index), 0);
    check("rst_data", int'(core_data), 0);
    check("rst_load", int'(core_load), 0);
    check("rst_run", int'(core_run), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // CONFIG MADD
    push_byte(8'h02);
    acc = last_acc;
    compare_events("cfg");
    check("cfg_insn_latency", (last_obs.size() > 0) ? last_obs[0].t - acc : -1, 2);
    check("cfg_busy_fall", busy_fall_t - acc, 3);
    check("cfg_insn_val", int'(core_insn), 2);

    // LOAD index 5, data 9
    push_byte(8'h45);
    push_byte(8'hF9);
    compare_events("load");
    check("load_index_hold", int'(core_index), 5);
    check("load_data_hold", int'(core_data), 9);

    // RUN 3 and RUN 0 (=64)
    push_byte(8'h83);
    acc = last_acc;
    compare_events("run3");
    check("run3_latency", (last_obs.size() > 0) ? last_obs[0].t - acc : -1, 2);
    push_byte(8'h80);
    compare_events("run64");

    // Backpressure behind a long RUN
    push_byte(8'hBF);
    wait_run("bp_run_start");
    n_before = 0;
    stall_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (!cmd_ready) stall_seen = 1;
      else if (stall_seen == 0) n_before++;
      push_byte(bp_bytes[i]);
    end
`ifdef MM_SEQ_BUFFER_EN
    check("bp_accept_before_stall", n_before, 4);
`else
    check("bp_accept_before_stall", n_before, 1);
`endif
    compare_events("bp");

    // CRST queued during a RUN
    push_byte(8'h90);
    wait_run("crst_run_start");
    push_byte(8'hC0);
    compare_events("crst");

    // Randomized command streams
    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 12; c++) begin
        int op;
        op = $urandom_range(0, 3);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        case (op)
          0: push_byte({2'b00, 4'($urandom), 2'($urandom)});
          1: begin
            push_byte({2'b01, 2'($urandom), 4'($urandom)});
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_byte(8'($urandom));
          end
          2: push_byte({2'b10, 6'($urandom_range(0, 12))});
          default: push_byte({2'b11, 6'($urandom)});
        endcase
      end
      compare_events("rand");
    end

    // Asynchronous reset in the middle of a RUN with a command queued
    push_byte(8'h80);
    wait_run("arst_run_start");
    repeat (5) @(negedge clk);
    push_byte(8'h02);
    repeat (3) @(negedge clk);
    check("arst_run_before", int'(core_run), 1);
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_run_cleared", int'(core_run), 0);
    check("arst_busy_cleared", int'(busy), 0);
    check("arst_ready_low", int'(cmd_ready), 0);
    check("arst_core_rst_n", int'(core_rst_n), 0);
    check("arst_insn", int'(core_insn), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sent_q.delete();
    obs_q.delete();
    model_insn = 0;
    @(negedge clk);
    check("arst_ready_after", int'(cmd_ready), 1);
    @(negedge clk);
    mon_en = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_no_events", obs_q.size(), 0);
    check("arst_queue_dropped_insn", int'(core_insn), 0);
    check("arst_idle_busy", int'(busy), 0);
    check("arst_idle_run", int'(core_run), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_cmd_sequencer.md
# mm_cmd_sequencer

Byte-stream command sequencer that sits directly upstream of the multi-MAC core and drives its index/data/insn/load/run/reset pins. Commands arrive on an 8-bit valid/ready stream and are buffered. They are decoded and replayed as correctly spaced control pulses, so the host never has to meet the core's cycle-level pin protocol. One clock domain; all outputs are registered.

## Interface
- CMD_DEPTH, 4, command buffer depth in bytes (power of two, ≥2); ignored when the buffer is compiled out
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command byte present
- cmd_data  in  8  command byte
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready
- core_rst_n  out  1  reset to core, active low
- core_insn  out  2  operation select (00 MIN, 01 MAX, 10 MADD)
- core_index  out  4  memory index
- core_data  out  4  load data nibble
- core_load  out  1  load strobe
- core_run  out  1  run enable
- busy  out  1  buffer non-empty or FSM not in IDLE

## Operation
- Opcode is cmd_data[7:6].
  - 00 CONFIG: core_insn <= cmd_data[1:0]. Code 11 is illegal: ignored, insn unchanged.
  - 01 LOAD: header byte, cmd_data[3:0] = index. The next byte's [3:0] = data; its [7:4] are ignored.
  - 10 RUN: cmd_data[5:0] = N. core_run is held high for N cycles; N=0 means 64.
  - 11 CRST: core_rst_n low for exactly 2 cycles.
- FSM states: IDLE, DECODE, LD_WAIT, LD_PULSE, RUN, CRST, GAP.
  - IDLE -> DECODE when buffer non-empty. DECODE pops one byte.
  - CONFIG -> GAP.
  - LOAD -> LD_WAIT (waits for the data byte) -> LD_PULSE (core_load=1 for one cycle, index/data stable) -> GAP.
  - RUN -> RUN (countdown) -> GAP.
  - CRST -> CRST (2 cycles) -> GAP.
  - GAP: one cycle with load=0, run=0, rst_n=1 (the core's initialise slot), then IDLE.
- core_index/core_data/core_insn hold their last values between commands.
- Run counter is 7 bits and loads 64 when N=0. RUN exits on count reaching 1 so that exactly N cycles are high.
- core_load and core_run are never high in the same cycle. core_rst_n is never low while load or run is high.
- Buffer: cmd_ready = !full.
  - A write and a pop in the same cycle on a full buffer is allowed only when the pop frees space first. Because cmd_ready is registered from the full flag, the same-cycle write is refused in that case.
  - Pointers wrap modulo CMD_DEPTH. The count register is one bit wider than the pointers.
- Reset values: cmd_ready=0 during reset and 1 from the first clock after release; core_rst_n=0; core_insn=00; core_index=0; core_data=0; core_load=0; core_run=0; busy=0; FSM=IDLE; buffer empty.
- Asserting rst_n low mid-command aborts immediately. Partial LOAD headers and remaining RUN counts are discarded.

## Timing
- Byte accepted at edge t is readable at t+1. DECODE occupies t+1.
- Registered effects:
  - CONFIG: core_insn changes at edge t+2.
  - LOAD: core_load is high in the cycle after the data byte is decoded.
  - RUN: core_run rises at edge t+2.
- Back-to-back commands are separated by at least the GAP cycle plus DECODE. Minimum spacing between strobes is 2 low cycles.
- Throughput: 1 byte/cycle into the buffer. The sustained drain rate is set by command length.

## Configuration
- MM_SEQ_BUFFER_EN defined: CMD_DEPTH-entry circular buffer as described.
- Not defined: single-byte holding register.
  - cmd_ready = register empty.
  - Latency is unchanged, but the host stalls during every command.
  - busy = register full || FSM != IDLE.

## Structure
- Package mm_seq_pkg:
  - opcode constants OP_CONFIG/OP_LOAD/OP_RUN/OP_CRST
  - insn constants INSN_MIN/MAX/MADD
  - state enum
  - RUN_ZERO_LEN=64
  - CRST_LEN=2
- One sub-module: mm_cmd_fifo (circular buffer, push/pop/full/empty/count). It is instantiated only under MM_SEQ_BUFFER_EN; otherwise a holding register is inferred inline.

## Test plan
- Reset release -> all outputs at reset values; cmd_ready=1 on the first edge; busy=0.
- Send 0x02 (CONFIG MADD) -> core_insn=10 two edges after acceptance; no load/run pulse; busy falls after GAP.
- Send 0x45 then 0xF9 -> exactly one cycle of core_load=1 with core_index=5, core_data=9; no run activity.
- Send 0x83 -> core_run high exactly 3 consecutive cycles. Send 0x80 -> high exactly 64 cycles.
- Push 8 bytes with the consumer busy on RUN 0xBF -> cmd_ready drops after 4 bytes (buffer on) or 1 (buffer off); no byte lost or duplicated; command order is preserved.
- Send 0xC0 during a RUN, then assert rst_n low mid-RUN -> CRST gives 2 low cycles of core_rst_n with load/run low. Async reset clears run and buffer within the same cycle.
